// File: rtl/softmax_axil_regs_if.sv
// rtl/softmax_axil_regs_if.sv - AXI4-Lite S00_AXI bundle between the bench master and the Softmax register file
interface softmax_axil_regs_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/softmax_axil_regs.sv
// rtl/softmax_axil_regs.sv - Softmax AXI4-Lite register file (CTRL/SRC/DST/LEN + STATUS), START pulse
// Optional SLVERR on unmapped/STATUS-write accesses: define SOFTMAX_AXIL_SLVERR_EN
module softmax_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  softmax_axil_regs_if.slave            s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] CTRL,
  output logic [C_S_AXI_DATA_WIDTH-1:0] SRC_ADDR,
  output logic [C_S_AXI_DATA_WIDTH-1:0] DST_ADDR,
  output logic [C_S_AXI_DATA_WIDTH-1:0] LEN,
  output logic                          START,
  input  logic                          BUSY,
  input  logic                          DONE
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  logic          init_q;
  logic          aw_held_q, aw_held_d;
  logic [2:0]    awidx_q, awidx_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          start_q, start_d;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];

  logic          aw_ready, w_ready, ar_ready, commit;
  logic [2:0]    aridx;
  logic [DW-1:0] rd_mux;
  logic [1:0]    wr_err, rd_err;
  logic          unused_ok;

  // Readies stay low while in reset and come up on the first edge after release.
  assign aw_ready = init_q && !aw_held_q && !bvalid_q;
  assign w_ready  = init_q && !w_held_q && !bvalid_q;
  assign ar_ready = init_q && !rvalid_q;
  assign commit   = aw_held_q && w_held_q;
  assign aridx    = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef SOFTMAX_AXIL_SLVERR_EN
  assign wr_err = (awidx_q > 3'd3) ? 2'b10 : 2'b00;
  assign rd_err = (aridx > 3'd4) ? 2'b10 : 2'b00;
`else
  assign wr_err = 2'b00;
  assign rd_err = 2'b00;
`endif

  always_comb begin
    rd_mux = '0;
    case (aridx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = regs_q[aridx[1:0]];
      3'd4:                   rd_mux = {{(DW-2){1'b0}}, DONE, BUSY};
      default:                rd_mux = '0;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awidx_d   = awidx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    start_d   = 1'b0;
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];

    if (s_axi.S_AXI_AWVALID && aw_ready) begin
      aw_held_d = 1'b1;
      awidx_d   = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (s_axi.S_AXI_WVALID && w_ready) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    // A commit can never coincide with a B handshake: readies are low while BVALID is up.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err;
      if (awidx_q < 3'd4) begin
        for (int b = 0; b < NB; b++)
          if (wstrb_q[b]) regs_d[awidx_q[1:0]][b*8 +: 8] = wdata_q[b*8 +: 8];
      end
      start_d = (awidx_q == 3'd0) && wstrb_q[0] && wdata_q[0];
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (s_axi.S_AXI_ARVALID && ar_ready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
      rresp_d  = rd_err;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      awidx_q   <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      start_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      init_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      awidx_q   <= awidx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      start_q   <= start_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign CTRL     = regs_q[0];
  assign SRC_ADDR = regs_q[1];
  assign DST_ADDR = regs_q[2];
  assign LEN      = regs_q[3];
  assign START    = start_q;

  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_softmax_axil_regs.sv
// tb/tb_softmax_axil_regs.sv - directed AXI4-Lite bench for softmax_axil_regs
module tb_softmax_axil_regs;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] CTRL, SRC_ADDR, DST_ADDR, LEN;
  logic        START;
  logic        BUSY = 1'b0;
  logic        DONE = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          start_with_b = 0;
  logic [1:0]  exp_err;
  logic [1:0]  resp;
  logic [31:0] rd;

  softmax_axil_regs_if axi ();

  softmax_axil_regs dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .s_axi    (axi.slave),
    .CTRL     (CTRL),
    .SRC_ADDR (SRC_ADDR),
    .DST_ADDR (DST_ADDR),
    .LEN      (LEN),
    .START    (START),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (START) begin
      start_cnt++;
      if (axi.S_AXI_BVALID) start_with_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] r);
    logic aw_done, w_done, aw_hs, w_hs;
    int   n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    axi.S_AXI_AWADDR = a; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = d; axi.S_AXI_WSTRB = st; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      step(); n++;
      if (aw_hs) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin axi.S_AXI_WVALID = 1'b0; w_done = 1'b1; end
    end
    while (!axi.S_AXI_BVALID && n < 50) begin step(); n++; end
    if (n >= 50) check("write_timeout", 32'(n), 32'd0);
    r = axi.S_AXI_BRESP;
    step();
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    axi.S_AXI_ARADDR = a; axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_RREADY = 1'b1;
    while (!axi.S_AXI_ARREADY && n < 50) begin step(); n++; end
    step();
    axi.S_AXI_ARVALID = 1'b0;
    while (!axi.S_AXI_RVALID && n < 50) begin step(); n++; end
    if (n >= 50) check("read_timeout", 32'(n), 32'd0);
    d = axi.S_AXI_RDATA; r = axi.S_AXI_RRESP;
    step();
    axi.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
`ifdef SOFTMAX_AXIL_SLVERR_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
`endif
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0;
    axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;

    step(); step();
    check("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    check("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    check("rst_ctrl", CTRL, 32'h0);
    check("rst_start", 32'(START), 32'd0);
    ARESET = 1'b0;
    step();
    check("post_rst_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
    check("post_rst_wready", 32'(axi.S_AXI_WREADY), 32'd1);
    check("post_rst_arready", 32'(axi.S_AXI_ARREADY), 32'd1);

    // Basic write/readback of all four config registers
    axi_write(5'h00, 32'h0101FFFF, 4'hF, resp); check("w_ctrl_resp", 32'(resp), 32'd0);
    axi_write(5'h04, 32'hABCD0001, 4'hF, resp); check("w_src_resp", 32'(resp), 32'd0);
    axi_write(5'h08, 32'hDEAD0011, 4'hF, resp); check("w_dst_resp", 32'(resp), 32'd0);
    axi_write(5'h0C, 32'hBEEF0011, 4'hF, resp); check("w_len_resp", 32'(resp), 32'd0);
    axi_read(5'h00, rd, resp); check("r_ctrl", rd, 32'h0101FFFF); check("r_ctrl_resp", 32'(resp), 32'd0);
    axi_read(5'h04, rd, resp); check("r_src", rd, 32'hABCD0001);
    axi_read(5'h08, rd, resp); check("r_dst", rd, 32'hDEAD0011);
    axi_read(5'h0C, rd, resp); check("r_len", rd, 32'hBEEF0011); check("r_len_resp", 32'(resp), 32'd0);
    check("o_ctrl", CTRL, 32'h0101FFFF);
    check("o_src", SRC_ADDR, 32'hABCD0001);
    check("o_dst", DST_ADDR, 32'hDEAD0011);
    check("o_len", LEN, 32'hBEEF0011);
    axi_read(5'h07, rd, resp); check("r_src_lowbits_ignored", rd, 32'hABCD0001);

    // Byte-lane strobes
    axi_write(5'h0C, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(5'h0C, 32'h12345678, 4'b0101, resp);
    axi_read(5'h0C, rd, resp); check("r_len_strb", rd, 32'hFF34FF78);

    // W three cycles before AW, BREADY held low for 5 cycles
    axi.S_AXI_WDATA = 32'h55AA55AA; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_BREADY = 1'b0;
    check("wfirst_wready", 32'(axi.S_AXI_WREADY), 32'd1);
    step();
    axi.S_AXI_WVALID = 1'b0;
    check("wheld_wready", 32'(axi.S_AXI_WREADY), 32'd0);
    step(); step();
    check("wheld_src_unchanged", SRC_ADDR, 32'hABCD0001);
    axi.S_AXI_AWADDR = 5'h04; axi.S_AXI_AWVALID = 1'b1;
    check("late_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
    step();
    axi.S_AXI_AWVALID = 1'b0;
    check("precommit_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("precommit_src", SRC_ADDR, 32'hABCD0001);
    step();
    check("commit_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    check("commit_src", SRC_ADDR, 32'h55AA55AA);
    for (int i = 0; i < 5; i++) begin
      check("bhold_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
      check("bhold_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
      check("bhold_wready", 32'(axi.S_AXI_WREADY), 32'd0);
      step();
    end
    axi.S_AXI_BREADY = 1'b1;
    step();
    axi.S_AXI_BREADY = 1'b0;
    check("bdone_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("bdone_awready", 32'(axi.S_AXI_AWREADY), 32'd1);

    // START pulse
    start_cnt = 0; start_with_b = 0;
    axi_write(5'h00, 32'h00000001, 4'hF, resp);
    check("start_count", 32'(start_cnt), 32'd1);
    check("start_with_bvalid", 32'(start_with_b), 32'd1);
    check("start_ctrl_stored", CTRL, 32'h00000001);
    start_cnt = 0;
    axi_write(5'h00, 32'h00000000, 4'hF, resp);
    check("nostart_count", 32'(start_cnt), 32'd0);

    // STATUS and unmapped addresses
    BUSY = 1'b1; DONE = 1'b0;
    axi_read(5'h10, rd, resp); check("r_status_busy", rd, 32'h1); check("r_status_resp", 32'(resp), 32'd0);
    BUSY = 1'b0; DONE = 1'b1;
    axi_read(5'h10, rd, resp); check("r_status_done", rd, 32'h2);
    axi_read(5'h18, rd, resp); check("r_unmapped", rd, 32'h0); check("r_unmapped_resp", 32'(resp), 32'(exp_err));
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, resp); check("w_status_resp", 32'(resp), 32'(exp_err));
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, resp); check("w_unmapped_resp", 32'(resp), 32'(exp_err));
    check("w_unmapped_ctrl", CTRL, 32'h0);
    check("w_unmapped_src", SRC_ADDR, 32'h55AA55AA);
    DONE = 1'b0;

    // Reset with both responses pending
    axi.S_AXI_AWADDR = 5'h08; axi.S_AXI_WDATA = 32'h00001234; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = 5'h04; axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_RREADY = 1'b0;
    step();
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    step();
    check("pend_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    check("pend_rvalid", 32'(axi.S_AXI_RVALID), 32'd1);
    check("pend_rdata", axi.S_AXI_RDATA, 32'h55AA55AA);
    #2;
    ARESET = 1'b1;
    #1;
    check("arst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("arst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    check("arst_rdata", axi.S_AXI_RDATA, 32'h0);
    check("arst_src", SRC_ADDR, 32'h0);
    check("arst_dst", DST_ADDR, 32'h0);
    step(); step();
    ARESET = 1'b0;
    step();
    axi_read(5'h04, rd, resp); check("post_arst_src", rd, 32'h0);
    check("post_arst_no_b", 32'(axi.S_AXI_BVALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/softmax_axil_regs.md
# softmax_axil_regs

AXI4-Lite slave register file for the Softmax layer IP; the responder for the `S00_AXI` interface driven by the AXI4-Lite master BFM in the bench. It holds four read/write configuration registers and one read-only status register. It drives configuration outputs and a one-cycle start pulse into the Softmax datapath.

## Interface

**Parameters**
- `C_S_AXI_DATA_WIDTH`, default 32: data bus width. Only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, default 5: byte address width. Decode uses bits [4:2].

**Ports** (one clock; reset is asynchronous and active-high)
- `ACLK` in 1: clock; all state changes on the rising edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `S_AXI_AWADDR` in 5, `S_AXI_AWPROT` in 3 (ignored), `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_ARADDR` in 5, `S_AXI_ARPROT` in 3 (ignored), `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data channel.
- `CTRL`, `SRC_ADDR`, `DST_ADDR`, `LEN` out 32 each: current register contents.
- `START` out 1: one-cycle pulse.
- `BUSY`, `DONE` in 1 each: datapath status.

## Operation

**Register map**
- 0x00 `CTRL`: read/write.
- 0x04 `SRC_ADDR`: read/write.
- 0x08 `DST_ADDR`: read/write.
- 0x0C `LEN`: read/write.
- 0x10 `STATUS`: read-only, value {30'b0, `DONE`, `BUSY`}, sampled when the read address is accepted.
- 0x14–0x1C: unmapped.

**Write path**
- AW and W are accepted independently, in either order. Each channel has its own holding register and valid flag.
- `AWREADY` = !aw_held && !`BVALID`. `WREADY` = !w_held && !`BVALID`.
- When aw_held and w_held are both set, the write commits on the next edge:
  - Byte lanes with their `WSTRB` bit set are written. Other lanes keep their value.
  - `BVALID` is set on the same edge, and both held flags clear.
- Writes to `STATUS` or to unmapped addresses change no state. The response is OKAY (see Configuration).
- `BVALID` stays high until the edge on which `BREADY` is sampled high.

**START pulse**
- `START` goes high for exactly one cycle on the commit edge of a write to 0x00 with `WSTRB[0]`=1 and `WDATA[0]`=1.
- The written value is stored in `CTRL` unchanged.

**Read path**
- `ARREADY` = !`RVALID`.
- On the AR handshake edge, `RDATA` and `RRESP` are registered and `RVALID` is set.
- `RDATA` and `RRESP` stay stable until the edge on which `RVALID` && `RREADY`; `RVALID` clears on that edge.
- Unmapped reads return 0x00000000.

**Boundary conditions**
- If a write commit and an AR handshake to the same address fall on the same edge, the read returns the pre-write value.
- Read and write paths are fully independent; one outstanding transaction per direction.
- Address bits [1:0] are ignored.
- An `ARESET` assertion mid-transaction aborts the transaction immediately. No response is issued for it after reset.

## Timing

**Reset values:** all registers, held flags, `BVALID`, `RVALID`, `RDATA` and `START` are 0. `AWREADY`, `WREADY` and `ARREADY` are 1 from the first edge after reset release.

**Write latency**
- AW and W handshakes on the same edge N: registers update and `BVALID` rises at edge N+1.
- Handshakes on different edges: commit is one edge after the later handshake.
- Next AW/W handshake: no earlier than the edge after the B handshake.

**Read latency**
- `RVALID` rises on the AR handshake edge, so data is visible in the following cycle.
- Back-to-back reads with `RREADY` tied high: one read every 2 cycles.

## Configuration

**`SOFTMAX_AXIL_SLVERR_EN`**
- Defined: accesses to unmapped addresses, and writes to `STATUS`, return `BRESP`/`RRESP` = 2'b10 (SLVERR). Unmapped reads still return 0.
- Undefined: every response is 2'b00 (OKAY).

## Test plan

1. Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x00/0x04/0x08/0x0C, then read each back -> `RDATA` equals the written value, all responses OKAY, `CTRL`..`LEN` outputs match.
2. Write `LEN` = 0xFFFFFFFF, then write 0x12345678 with `WSTRB` = 4'b0101 -> readback 0xFF34FF78.
3. Present W three cycles before AW, and hold `BREADY` low for 5 cycles -> `BVALID` held; `AWREADY`/`WREADY` stay low until the B handshake; the register updates only on commit.
4. Write 0x00000001 to 0x00 -> `START` high for exactly one cycle, coincident with `BVALID` rising; writing 0x00000000 produces no pulse.
5. Drive `BUSY`=1, `DONE`=0 and read 0x10 -> 0x00000001. Read 0x18 -> 0x00000000. Responses are OKAY, or SLVERR when `SOFTMAX_AXIL_SLVERR_EN` is defined.
6. Assert `ARESET` while `RVALID` and `BVALID` are pending -> all outputs return to 0 immediately and registers clear; a subsequent read of 0x04 returns 0.
